// File: rtl/regfile_bypass_scoreboard.sv
// regfile_bypass_scoreboard
//   Multi-port general-purpose register file with two prioritised write
//   ports, same-cycle write-to-read bypass and a per-register busy
//   scoreboard for RAW hazard detection.
//   Register 0 reads as zero, is never written and is never busy.
//   Optional feature: define REGFILE_BYTE_WRITE_EN to add per-byte write
//   enables on write port 0 (Write_Byte_Enable_0).
module regfile_bypass_scoreboard #(
    parameter int REGSIZE    = 5,
    parameter int DIGIT      = 32,
    parameter int READ_PORTS = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [READ_PORTS*REGSIZE-1:0] Read_Address,
    output logic [READ_PORTS*DIGIT-1:0]   Read_Data,
    output logic [READ_PORTS-1:0]         Read_Busy,
    input  logic                          Write_Enable_0,
    input  logic [REGSIZE-1:0]            Write_Address_0,
    input  logic [DIGIT-1:0]              Write_Data_0,
`ifdef REGFILE_BYTE_WRITE_EN
    input  logic [DIGIT/8-1:0]            Write_Byte_Enable_0,
`endif
    input  logic                          Write_Enable_1,
    input  logic [REGSIZE-1:0]            Write_Address_1,
    input  logic [DIGIT-1:0]              Write_Data_1,
    input  logic                          Reserve_Enable,
    input  logic [REGSIZE-1:0]            Reserve_Address,
    output logic [REGSIZE:0]              Busy_Count,
    output logic                          Conflict
);

    localparam int unsigned NREGS = 1 << REGSIZE;

    logic [DIGIT-1:0]   mem [NREGS];
    logic [NREGS-1:0]   busy;
    logic [NREGS-1:0]   busy_next;

    logic               we0;
    logic               we1;
    logic               res;
    logic               full0;
    logic               clr0;
    logic               clr1;
    logic [DIGIT-1:0]   wmask0;

    logic               rise;
    logic               fall0;
    logic               fall1;
    logic [REGSIZE:0]   count_next;

    logic [REGSIZE-1:0] rd_addr;
    logic               hit0;
    logic               hit1;
    logic [DIGIT-1:0]   rd_word;

`ifdef REGFILE_BYTE_WRITE_EN
    // Expand port-0 byte enables into a bit mask; only a full-word write retires a producer
    always_comb begin
        wmask0 = '0;
        for (int unsigned b = 0; b < DIGIT / 8; b++) begin
            wmask0[b*8 +: 8] = {8{Write_Byte_Enable_0[b]}};
        end
        full0 = &Write_Byte_Enable_0;
    end
`else
    // Port 0 always writes the full word
    always_comb begin
        wmask0 = '1;
        full0  = 1'b1;
    end
`endif

    // Qualify writes and reservations: address 0 is inert on every port
    always_comb begin
        we0  = Write_Enable_0 && (Write_Address_0 != '0);
        we1  = Write_Enable_1 && (Write_Address_1 != '0);
        res  = Reserve_Enable && (Reserve_Address != '0);
        clr0 = we0 && full0;
        clr1 = we1;
    end

    // Combinational read ports with write-to-read bypass (port 1 beats port 0 beats storage)
    always_comb begin
        Read_Data = '0;
        Read_Busy = '0;
        rd_addr   = '0;
        hit0      = 1'b0;
        hit1      = 1'b0;
        rd_word   = '0;
        for (int unsigned k = 0; k < READ_PORTS; k++) begin
            rd_addr = Read_Address[k*REGSIZE +: REGSIZE];
            hit1    = we1 && (Write_Address_1 == rd_addr);
            hit0    = we0 && (Write_Address_0 == rd_addr);
            if (hit1) begin
                rd_word = Write_Data_1;
            end else if (hit0) begin
                rd_word = (Write_Data_0 & wmask0) | (mem[rd_addr] & ~wmask0);
            end else begin
                rd_word = mem[rd_addr];
            end
            if (rd_addr != '0) begin
                Read_Data[k*DIGIT +: DIGIT] = rd_word;
                // A partial byte write does not retire the producer, so the operand stays busy
                Read_Busy[k] = busy[rd_addr] && !(hit1 || (hit0 && full0));
            end
        end
    end

    // Next scoreboard state: writebacks clear, then a reservation sets (new producer wins)
    always_comb begin
        busy_next = busy;
        if (clr0) begin
            busy_next[Write_Address_0] = 1'b0;
        end
        if (clr1) begin
            busy_next[Write_Address_1] = 1'b0;
        end
        if (res) begin
            busy_next[Reserve_Address] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Incremental busy count: one possible rise, up to two distinct falls per edge
    always_comb begin
        rise  = res && !busy[Reserve_Address];
        fall0 = clr0 && busy[Write_Address_0]
                && !(res && (Reserve_Address == Write_Address_0));
        fall1 = clr1 && busy[Write_Address_1]
                && !(res && (Reserve_Address == Write_Address_1))
                && !(clr0 && (Write_Address_0 == Write_Address_1));
        count_next = Busy_Count
                     + {{REGSIZE{1'b0}}, rise}
                     - {{REGSIZE{1'b0}}, fall0}
                     - {{REGSIZE{1'b0}}, fall1};
    end

    // Register storage; port 1 is written last so it wins an address collision
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we0) begin
                mem[Write_Address_0] <= (Write_Data_0 & wmask0)
                                        | (mem[Write_Address_0] & ~wmask0);
            end
            if (we1) begin
                mem[Write_Address_1] <= Write_Data_1;
            end
        end
    end

    // Scoreboard busy bits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Busy register count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Busy_Count <= '0;
        end else begin
            Busy_Count <= count_next;
        end
    end

    // Write-port collision flag, one cycle after both ports hit the same register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Conflict <= 1'b0;
        end else begin
            Conflict <= we0 && we1 && (Write_Address_0 == Write_Address_1);
        end
    end

endmodule

// File: tb/tb_regfile_bypass_scoreboard.sv
// Testbench for regfile_bypass_scoreboard: directed scenarios plus
// randomized traffic checked against an array-based reference model.
module tb_regfile_bypass_scoreboard;

    localparam int RS = 5;
    localparam int DW = 32;
    localparam int RP = 3;
    localparam int N  = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [RP*RS-1:0]  Read_Address;
    logic [RP*DW-1:0]  Read_Data;
    logic [RP-1:0]     Read_Busy;
    logic              we0 = 1'b0;
    logic [RS-1:0]     a0  = '0;
    logic [DW-1:0]     d0  = '0;
    logic [3:0]        be0 = 4'hF;
    logic              we1 = 1'b0;
    logic [RS-1:0]     a1  = '0;
    logic [DW-1:0]     d1  = '0;
    logic              re  = 1'b0;
    logic [RS-1:0]     ra  = '0;
    logic [RS:0]       Busy_Count;
    logic              Conflict;

    logic [RS-1:0]     rd [RP];

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    logic [DW-1:0] m_mem  [N];
    bit            m_busy [N];
    bit            exp_conf;

    regfile_bypass_scoreboard #(
        .REGSIZE    (RS),
        .DIGIT      (DW),
        .READ_PORTS (RP)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .Read_Address        (Read_Address),
        .Read_Data           (Read_Data),
        .Read_Busy           (Read_Busy),
        .Write_Enable_0      (we0),
        .Write_Address_0     (a0),
        .Write_Data_0        (d0),
`ifdef REGFILE_BYTE_WRITE_EN
        .Write_Byte_Enable_0 (be0),
`endif
        .Write_Enable_1      (we1),
        .Write_Address_1     (a1),
        .Write_Data_1        (d1),
        .Reserve_Enable      (re),
        .Reserve_Address     (ra),
        .Busy_Count          (Busy_Count),
        .Conflict            (Conflict)
    );

    always #5 clock = ~clock;

    always_comb begin
        Read_Address = '0;
        for (int k = 0; k < RP; k++) begin
            Read_Address[k*RS +: RS] = rd[k];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] merge0(input logic [DW-1:0] old);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < DW / 8; b++) begin
            if (be0[b]) r[b*8 +: 8] = d0[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [RS-1:0] a);
        if (a == 0) return '0;
        if (we1 && a1 == a) return d1;
        if (we0 && a0 == a) return merge0(m_mem[a]);
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input logic [RS-1:0] a);
        if (a == 0) return 1'b0;
        if (we1 && a1 == a) return 1'b0;
        if (we0 && a0 == a && be0 == 4'hF) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int m_count();
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        exp_conf = 1'b0;
    endtask

    // advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        @(posedge clock);
        exp_conf = we0 && we1 && (a0 == a1) && (a0 != 0);
        if (we0 && a0 != 0) m_mem[a0] = merge0(m_mem[a0]);
        if (we1 && a1 != 0) m_mem[a1] = d1;
        if (we0 && a0 != 0 && be0 == 4'hF) m_busy[a0] = 1'b0;
        if (we1 && a1 != 0) m_busy[a1] = 1'b0;
        if (re && ra != 0) m_busy[ra] = 1'b1;
        @(negedge clock);
    endtask

    task automatic idle();
        we0 = 1'b0;
        we1 = 1'b0;
        re  = 1'b0;
        be0 = 4'hF;
    endtask

    function automatic logic [RS-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return RS'($urandom_range(0, N - 1));
        return RS'($urandom_range(0, 7));
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (Busy_Count !== '0) begin
            miscompares++;
            $display("FAIL reset_count: got %0d expected 0", Busy_Count);
        end
        vectors++;
        if (Conflict !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_conflict: got %b expected 0", Conflict);
        end
        for (int a = 0; a < N; a++) begin
            for (int k = 0; k < RP; k++) rd[k] = RS'(a);
            #1;
            for (int k = 0; k < RP; k++) begin
                vectors++;
                if (Read_Data[k*DW +: DW] !== '0 || Read_Busy[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_read a=%0d port=%0d: got %h/%b expected 0/0",
                             a, k, Read_Data[k*DW +: DW], Read_Busy[k]);
                end
            end
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_r0();
        idle();
        we0 = 1'b1; a0 = 0; d0 = 32'hFFFF_FFFF;
        we1 = 1'b1; a1 = 0; d1 = 32'hFFFF_FFFF;
        re  = 1'b1; ra = 0;
        for (int k = 0; k < RP; k++) rd[k] = 0;
        #1;
        for (int k = 0; k < RP; k++) begin
            vectors++;
            if (Read_Data[k*DW +: DW] !== '0 || Read_Busy[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL r0_bypass port=%0d: got %h/%b expected 0/0",
                         k, Read_Data[k*DW +: DW], Read_Busy[k]);
            end
        end
        tick();
        idle();
        #1;
        vectors++;
        if (Read_Data[0 +: DW] !== '0) begin
            miscompares++;
            $display("FAIL r0_stored: got %h expected 0", Read_Data[0 +: DW]);
        end
        vectors++;
        if (Conflict !== 1'b0 || Busy_Count !== '0) begin
            miscompares++;
            $display("FAIL r0_flags: got conflict=%b count=%0d expected 0/0", Conflict, Busy_Count);
        end
    endtask

    task automatic test_bypass();
        idle();
        rd[2] = 5;
        we0 = 1'b1; a0 = 5; d0 = 32'h1234_5678;
        #1;
        vectors++;
        if (Read_Data[2*DW +: DW] !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL bypass_same_cycle: got %h expected 12345678", Read_Data[2*DW +: DW]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (Read_Data[2*DW +: DW] !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL bypass_next_cycle: got %h expected 12345678", Read_Data[2*DW +: DW]);
        end
        we0 = 1'b1; a0 = 5; d0 = 32'hA;
        we1 = 1'b1; a1 = 5; d1 = 32'hB;
        #1;
        vectors++;
        if (Read_Data[2*DW +: DW] !== 32'hB) begin
            miscompares++;
            $display("FAIL conflict_bypass: got %h expected b", Read_Data[2*DW +: DW]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (Conflict !== 1'b1) begin
            miscompares++;
            $display("FAIL conflict_pulse: got %b expected 1", Conflict);
        end
        vectors++;
        if (Read_Data[2*DW +: DW] !== 32'hB) begin
            miscompares++;
            $display("FAIL conflict_stored: got %h expected b", Read_Data[2*DW +: DW]);
        end
        tick();
        vectors++;
        if (Conflict !== 1'b0) begin
            miscompares++;
            $display("FAIL conflict_single_cycle: got %b expected 0", Conflict);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        re = 1'b1; ra = 7;
        rd[0] = 7;
        #1;
        vectors++;
        if (Read_Busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reserve_same_cycle: got %b expected 0", Read_Busy[0]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (Read_Busy[0] !== 1'b1 || Busy_Count !== 6'd1) begin
            miscompares++;
            $display("FAIL reserve_r7: got busy=%b count=%0d expected 1/1", Read_Busy[0], Busy_Count);
        end
        we0 = 1'b1; a0 = 7; d0 = 32'h55;
        #1;
        vectors++;
        if (Read_Busy[0] !== 1'b0 || Read_Data[0 +: DW] !== 32'h55) begin
            miscompares++;
            $display("FAIL writeback_release: got busy=%b data=%h expected 0/55",
                     Read_Busy[0], Read_Data[0 +: DW]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (Busy_Count !== 6'd0 || Read_Busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL writeback_count: got count=%0d busy=%b expected 0/0", Busy_Count, Read_Busy[0]);
        end
    endtask

    task automatic test_reserve_write();
        idle();
        re = 1'b1; ra = 9;
        tick();
        re = 1'b1; ra = 9;
        we1 = 1'b1; a1 = 9; d1 = 32'h3;
        tick();
        idle();
        rd[1] = 9;
        #1;
        vectors++;
        if (Read_Data[DW +: DW] !== 32'h3 || Read_Busy[1] !== 1'b1 || Busy_Count !== 6'd1) begin
            miscompares++;
            $display("FAIL reserve_and_write: got data=%h busy=%b count=%0d expected 3/1/1",
                     Read_Data[DW +: DW], Read_Busy[1], Busy_Count);
        end
        re = 1'b1; ra = 4;
        tick();
        idle();
        re = 1'b1; ra = 3;
        we0 = 1'b1; a0 = 4; d0 = 32'h44;
        tick();
        idle();
        rd[0] = 3; rd[1] = 4;
        #1;
        vectors++;
        if (Busy_Count !== 6'd2 || Read_Busy[0] !== 1'b1 || Read_Busy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL reserve_other_write: got count=%0d r3=%b r4=%b expected 2/1/0",
                     Busy_Count, Read_Busy[0], Read_Busy[1]);
        end
    endtask

`ifdef REGFILE_BYTE_WRITE_EN
    task automatic test_byte_write();
        idle();
        we1 = 1'b1; a1 = 2; d1 = 32'hAABB_CCDD;
        re  = 1'b1; ra = 2;
        tick();
        idle();
        rd[0] = 2;
        we0 = 1'b1; a0 = 2; d0 = 32'h1122_3344; be0 = 4'b0101;
        #1;
        vectors++;
        if (Read_Data[0 +: DW] !== 32'hAA22_CC44 || Read_Busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL byte_bypass: got %h/%b expected aa22cc44/1", Read_Data[0 +: DW], Read_Busy[0]);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (Read_Data[0 +: DW] !== 32'hAA22_CC44 || Read_Busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL byte_stored: got %h/%b expected aa22cc44/1", Read_Data[0 +: DW], Read_Busy[0]);
        end
        we0 = 1'b1; a0 = 2; d0 = 32'h0; be0 = 4'hF;
        tick();
        idle();
        #1;
        vectors++;
        if (Read_Busy[0] !== 1'b0 || Read_Data[0 +: DW] !== '0) begin
            miscompares++;
            $display("FAIL byte_full_clear: got %h/%b expected 0/0", Read_Data[0 +: DW], Read_Busy[0]);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            we0 = 1'($urandom_range(0, 1)); a0 = rand_addr(); d0 = $urandom;
            we1 = 1'($urandom_range(0, 2) == 0); a1 = rand_addr(); d1 = $urandom;
            re  = 1'($urandom_range(0, 1)); ra = rand_addr();
`ifdef REGFILE_BYTE_WRITE_EN
            be0 = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
`endif
            for (int k = 0; k < RP; k++) rd[k] = rand_addr();
            #1;
            for (int k = 0; k < RP; k++) begin
                vectors++;
                if (Read_Data[k*DW +: DW] !== exp_data(rd[k]) || Read_Busy[k] !== exp_busy(rd[k])) begin
                    miscompares++;
                    $display("FAIL random_read cyc=%0d port=%0d addr=%0d: got %h/%b expected %h/%b",
                             c, k, rd[k], Read_Data[k*DW +: DW], Read_Busy[k],
                             exp_data(rd[k]), exp_busy(rd[k]));
                end
            end
            tick();
            vectors++;
            if (Busy_Count !== (RS+1)'(m_count()) || Conflict !== exp_conf) begin
                miscompares++;
                $display("FAIL random_regs cyc=%0d: got count=%0d conflict=%b expected %0d/%b",
                         c, Busy_Count, Conflict, m_count(), exp_conf);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        for (int a = 1; a < N; a++) begin
            re = 1'b1; ra = RS'(a);
            we1 = (a == 1); a1 = 6; d1 = 32'hDEAD_BEEF;
            tick();
        end
        idle();
        #1;
        vectors++;
        if (Busy_Count !== 6'd31) begin
            miscompares++;
            $display("FAIL reserve_all_count: got %0d expected 31", Busy_Count);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (Busy_Count !== '0 || Conflict !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_flags: got count=%0d conflict=%b expected 0/0", Busy_Count, Conflict);
        end
        for (int a = 0; a < N; a++) begin
            for (int k = 0; k < RP; k++) rd[k] = RS'(a);
            #1;
            vectors++;
            if (Read_Data[0 +: DW] !== '0 || Read_Busy[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL async_reset_read a=%0d: got %h/%b expected 0/0",
                         a, Read_Data[0 +: DW], Read_Busy[0]);
            end
        end
        // writes and reservations presented while reset is held are discarded
        we1 = 1'b1; a1 = 10; d1 = 32'h77;
        re  = 1'b1; ra = 11;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle();
        model_reset();
        rd[0] = 10; rd[1] = 11;
        #1;
        vectors++;
        if (Read_Data[0 +: DW] !== '0 || Read_Busy[1] !== 1'b0 || Busy_Count !== '0) begin
            miscompares++;
            $display("FAIL reset_discard: got data=%h busy=%b count=%0d expected 0/0/0",
                     Read_Data[0 +: DW], Read_Busy[1], Busy_Count);
        end
    endtask

    initial begin
        for (int k = 0; k < RP; k++) rd[k] = '0;
        model_reset();
        test_reset();
        test_r0();
        test_bypass();
        test_scoreboard();
        test_reserve_write();
`ifdef REGFILE_BYTE_WRITE_EN
        test_byte_write();
`endif
        test_random();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
